rr_mux_arbiter_4: RTL and testbench
===================================

RR_MUX_ARBITER_4 -- requirements
Module: rr_mux_arbiter_4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the bit width of every data port.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 4 bits, where bit i means requester i offers a word.
REQ-005 The block SHALL have ports d0, d1, d2, d3, input, WIDTH bits each, the data words of requesters 0..3.
REQ-006 The block SHALL have port in_ready, output, 4 bits, where bit i means requester i's word is taken this cycle.
REQ-007 The block SHALL have port out_valid, output, 1 bit, meaning the output register holds a word.
REQ-008 The block SHALL have port out_data, output, WIDTH bits, the held word.
REQ-009 The block SHALL have port out_id, output, 2 bits, the index of the requester that supplied out_data.
REQ-010 The block SHALL have port out_ready, input, 1 bit, the downstream accept.

Function
REQ-011 Output stage SHALL be one register slot (out_valid, out_data, out_id); out_* driven from flops only.
REQ-012 can_load SHALL be (!out_valid | out_ready).
REQ-013 Arbiter SHALL keep a 2-bit priority pointer ptr; the winner is the first set bit of in_valid searched ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 in_ready SHALL be one-hot at the winner when can_load=1 and in_valid!=0, else 4'b0000; in_ready is combinational, with no dependency on its own value.
REQ-015 A transfer SHALL occur on an edge where in_valid[i] & in_ready[i]; the slot then loads out_data=d_i, out_id=i, out_valid=1, selecting d_i as a 4:1 mux on winner index.
REQ-016 After a transfer from requester i, ptr SHALL become (i+1) mod 4, wrapping 3->0; ptr SHALL be unchanged on cycles with no transfer.
REQ-017 Latency SHALL be exactly 1 cycle: a word accepted at edge N is visible on out_* after edge N.
REQ-018 When out_valid=1 and out_ready=0 (stall), out_valid, out_data and out_id SHALL hold stable, and in_ready SHALL be 0.
REQ-019 When out_valid=1 and out_ready=1 with a winner present, drain and load SHALL happen on the same edge, giving throughput of 1 word/cycle with no bubble.
REQ-020 When out_valid=1, out_ready=1 and in_valid=0, out_valid SHALL clear to 0 on the edge; out_data and out_id hold their last values.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 Fairness: with all 4 requesters continuously valid and out_ready=1, grants SHALL follow a strict cycle of 0,1,2,3,0,...; no requester waits more than 3 transfers.
REQ-023 Requesters dropping in_valid before being granted is legal; the arbiter SHALL re-evaluate each cycle with no stored grant.

Reset
REQ-024 While rst=1, the block SHALL immediately set out_valid=0, out_data=0, out_id=0, ptr=0, independent of clk.
REQ-025 in_ready SHALL be 0 while rst=1.
REQ-026 After rst deasserts, the first eligible edge SHALL arbitrate from ptr=0.
REQ-027 Reset asserted mid-stall SHALL discard the held word, with no later out_valid for it.

Verification
REQ-028 Reset, then in_valid=4'b1111 and d0..d3=1,2,3,4 held with out_ready=1 -> out_id sequence 0,1,2,3,0 and out_data 1,2,3,4,1 on consecutive cycles, out_valid=1 continuously from the 2nd cycle.
REQ-029 in_valid=4'b1000 only, ptr=0 -> in_ready=4'b1000; next cycle out_id=3, then ptr=0 (wrap); a following in_valid=4'b0001 is granted immediately.
REQ-030 Load d2=4'hA, then out_ready=0 for 5 cycles with in_valid=4'b1111 -> out_data=4'hA and out_id=2 stable, in_ready=0 throughout; out_ready=1 -> the next grant is requester 3.
REQ-031 One word in the slot, in_valid=0, out_ready=1 -> out_valid falls to 0 after one edge; ptr unchanged.
REQ-032 Assert rst asynchronously between edges during a stall with out_valid=1 -> out_valid=0 at once, in_ready=0; after release with in_valid=4'b0110 -> requester 1 wins first.
REQ-033 Random in_valid and out_ready for 10k cycles -> scoreboard sees every accepted word exactly once and in order, no out_* change during stall, and no requester skipped more than 3 times while valid.

Source files
------------

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin 4:1 arbiter feeding a single-slot output register; 1-cycle latency.
// Stalls (in_ready=0) while the slot is full and out_ready is low; drain+load on one edge.
module rr_mux_arbiter_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_id,
    input  logic             out_ready
);

    logic [1:0]       r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_id;

    logic             w_found;
    logic [1:0]       w_win;
    logic             w_can_load;
    logic             w_grant;
    logic [WIDTH-1:0] w_mux;

    // Scan from the farthest offset down so the closest requester to r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            logic [1:0] idx;
            idx = r_ptr + 2'(k);
            if (in_valid[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    assign w_can_load = !r_out_valid || out_ready;
    assign w_grant    = w_found && w_can_load && !rst;
    assign in_ready   = w_grant ? (4'b0001 << w_win) : 4'b0000;

    always_comb begin
        w_mux = d0;
        case (w_win)
            2'd0:    w_mux = d0;
            2'd1:    w_mux = d1;
            2'd2:    w_mux = d2;
            default: w_mux = d3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= 2'd0;
        end else if (w_grant) begin
            r_ptr       <= w_win + 2'd1;
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_out_id    <= w_win;
        end else if (out_ready) begin
            // Drain with nothing to replace it: data/id keep their last values.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Randomized bench for rr_mux_arbiter_4 against a rotation-search reference model and word scoreboard.
module tb_rr_mux_arbiter_4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_id;
    logic         out_ready;

    rr_mux_arbiter_4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int           m_ptr;
    bit           m_vld;
    logic [W-1:0] m_data;
    int           m_id;
    int           sb_q[$];
    bit           prev_stall;
    logic [W-1:0] prev_data;
    logic [1:0]   prev_id;
    int           skip[4];
    int           skip_max;

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [W-1:0] dsel(input int i);
        case (i)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_vld = 0; m_data = '0; m_id = 0;
        sb_q.delete();
        prev_stall = 0;
        for (int i = 0; i < 4; i++) skip[i] = 0;
    endtask

    // One clock: check at negedge, advance model, then step past the posedge.
    task automatic cycle(output int granted);
        int   g;
        bit   canld;
        logic [3:0] exp_rdy;
        int   obs;
        @(negedge clk);
        g = pick(in_valid, m_ptr);
        canld = !m_vld || out_ready;
        exp_rdy = (canld && g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_id", 32'(out_id), 32'(m_id));
        if (prev_stall) begin
            chk("stall_data", 32'(out_data), 32'(prev_data));
            chk("stall_id", 32'(out_id), 32'(prev_id));
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_id    = out_id;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("sb_word", {22'd0, out_id, 4'd0, out_data}, 32'(sb_q.pop_front()));
        end
        obs = -1;
        for (int i = 0; i < 4; i++) if (in_ready[i] && in_valid[i]) obs = i;
        for (int i = 0; i < 4; i++) begin
            if (!in_valid[i] || i == obs) skip[i] = 0;
            else if (obs >= 0) skip[i]++;
            if (skip[i] > skip_max) skip_max = skip[i];
        end
        if (exp_rdy != 0) begin
            m_vld = 1; m_data = dsel(g); m_id = g; m_ptr = (g + 1) % 4;
            sb_q.push_back((g << 8) | int'(dsel(g)));
        end else if (out_ready) begin
            m_vld = 0;
        end
        granted = (exp_rdy != 0) ? g : -1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int g;

    initial begin
        skip_max = 0;
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        model_reset();
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // All four valid, free-running drain: strict 0,1,2,3,0 rotation
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle(g);
            chk("rr_seq", 32'(g), 32'(k % 4));
        end
        cycle(g);

        // Lone requester 3 from ptr=0, then wrap to requester 0
        do_reset();
        in_valid = 4'b1000;
        cycle(g);
        chk("wrap_g3", 32'(g), 32'd3);
        in_valid = 4'b0001;
        cycle(g);
        chk("wrap_g0", 32'(g), 32'd0);

        // Load d2=A, stall five cycles, release: requester 3 next
        do_reset();
        d2 = 4'hA; in_valid = 4'b0100; out_ready = 1'b1;
        cycle(g);
        chk("stall_load", 32'(g), 32'd2);
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle(g);
            chk("stall_nogrant", 32'(g), 32'hFFFFFFFF);
        end
        out_ready = 1'b1;
        cycle(g);
        chk("after_stall", 32'(g), 32'd3);

        // Drain with nothing behind it; pointer stays at 0
        in_valid = 4'b0000;
        cycle(g);
        cycle(g);
        chk("drain_empty", 32'(out_valid), 32'd0);
        in_valid = 4'b1111;
        cycle(g);
        chk("ptr_kept", 32'(g), 32'd0);

        // Async reset in the middle of a stall
        out_ready = 1'b0;
        cycle(g);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        model_reset();
        rst = 1'b0;
        in_valid = 4'b0110; out_ready = 1'b1;
        cycle(g);
        chk("arst_first", 32'(g), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 10000; n++) begin
            in_valid  = 4'($urandom);
            d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom); d3 = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(g);
        end
        in_valid = 4'b0000; out_ready = 1'b1;
        cycle(g);
        cycle(g);
        chk("sb_left", 32'(sb_q.size()), 32'd0);
        chk("fair_max_skip_le3", 32'(skip_max <= 3), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
